// File: rtl/fadd_arb_if.sv
// Bundle of the fadd_arb ports: two requester operand/result channels plus the
// operand/result link to the shared adder.
interface fadd_arb_if;
  logic        req0_valid;
  logic        req1_valid;
  logic        req0_ready;
  logic        req1_ready;
  logic [31:0] req0_x1;
  logic [31:0] req0_x2;
  logic [31:0] req1_x1;
  logic [31:0] req1_x2;
  logic        rsp0_valid;
  logic        rsp1_valid;
  logic        rsp0_ready;
  logic        rsp1_ready;
  logic [31:0] rsp0_y;
  logic [31:0] rsp1_y;
  logic        rsp0_ovf;
  logic        rsp1_ovf;
  logic [31:0] fu_x1;
  logic [31:0] fu_x2;
  logic [31:0] fu_y;
  logic        fu_ovf;

  modport slave (
    input  req0_valid, req1_valid, req0_x1, req0_x2, req1_x1, req1_x2,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp1_valid, rsp0_y, rsp1_y, rsp0_ovf, rsp1_ovf,
    input  rsp0_ready, rsp1_ready,
    output fu_x1, fu_x2,
    input  fu_y, fu_ovf
  );

  modport master (
    output req0_valid, req1_valid, req0_x1, req0_x2, req1_x1, req1_x2,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp1_valid, rsp0_y, rsp1_y, rsp0_ovf, rsp1_ovf,
    output rsp0_ready, rsp1_ready,
    input  fu_x1, fu_x2,
    output fu_y, fu_ovf
  );
endinterface

// File: rtl/fadd_arb.sv
// Round-robin front end sharing one fixed-latency adder between two requesters;
// results return through per-requester FIFOs guarded by issue credits.
module fadd_arb #(
  parameter int unsigned LAT    = 2,
  parameter int unsigned QDEPTH = 2
) (
  input  logic      clk,
  input  logic      rst,
  fadd_arb_if.slave bus
);
  localparam int unsigned CW = 3;
  localparam int unsigned PW = 2;
  localparam int unsigned MD = 4;
  localparam logic [CW-1:0] CRED_MAX = CW'(QDEPTH);

  logic [1:0]     w_valid;
  logic [1:0]     w_rsp_ready;
  logic [1:0]     w_elig;
  logic [1:0]     w_grant;
  logic [1:0]     w_push;
  logic [1:0]     w_pop;
  logic [32:0]    w_head [2];
  logic           w_tail_v;
  logic           w_tail_id;

  logic           r_prio;
  logic [LAT-1:0] r_pv;
  logic [LAT-1:0] r_pid;
  logic [CW-1:0]  r_cred [2];
  logic [CW-1:0]  r_cnt  [2];
  logic [PW-1:0]  r_wptr [2];
  logic [PW-1:0]  r_rptr [2];
  logic [32:0]    r_mem  [2][MD];

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(QDEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Eligibility needs a free result slot; reset holds every grant low.
  always_comb begin
    w_valid     = {bus.req1_valid, bus.req0_valid};
    w_rsp_ready = {bus.rsp1_ready, bus.rsp0_ready};
    w_elig      = '0;
    for (int n = 0; n < 2; n++) begin
      w_elig[n] = w_valid[n] && (r_cred[n] != '0) && !rst;
    end
    w_grant    = '0;
    w_grant[0] = w_elig[0] && (!w_elig[1] || !r_prio);
    w_grant[1] = w_elig[1] && (!w_elig[0] ||  r_prio);
  end

  // Pipe tail lines up with fu_y; it steers the adder result into its FIFO.
  always_comb begin
    w_tail_v  = r_pv[LAT-1];
    w_tail_id = r_pid[LAT-1];
    w_push    = '0;
    w_pop     = '0;
    for (int n = 0; n < 2; n++) begin
      w_push[n] = w_tail_v && (w_tail_id == 1'(n));
      w_pop[n]  = (r_cnt[n] != '0) && w_rsp_ready[n];
      w_head[n] = (r_cnt[n] != '0) ? r_mem[n][r_rptr[n]] : '0;
    end
  end

  always_comb begin
    bus.req0_ready = w_grant[0];
    bus.req1_ready = w_grant[1];
    bus.fu_x1      = w_grant[0] ? bus.req0_x1 : (w_grant[1] ? bus.req1_x1 : '0);
    bus.fu_x2      = w_grant[0] ? bus.req0_x2 : (w_grant[1] ? bus.req1_x2 : '0);
    bus.rsp0_valid = (r_cnt[0] != '0);
    bus.rsp1_valid = (r_cnt[1] != '0);
    bus.rsp0_y     = w_head[0][31:0];
    bus.rsp0_ovf   = w_head[0][32];
    bus.rsp1_y     = w_head[1][31:0];
    bus.rsp1_ovf   = w_head[1][32];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prio <= 1'b0;
      r_pv   <= '0;
      r_pid  <= '0;
      for (int n = 0; n < 2; n++) begin
        r_cred[n] <= CRED_MAX;
        r_cnt[n]  <= '0;
        r_wptr[n] <= '0;
        r_rptr[n] <= '0;
      end
    end else begin
      // Priority passes to whichever requester was not served.
      if (|w_grant) r_prio <= w_grant[0];
      r_pv  <= LAT'({r_pv, |w_grant});
      r_pid <= LAT'({r_pid, w_grant[1]});
      for (int n = 0; n < 2; n++) begin
        r_cred[n] <= r_cred[n] - CW'(w_grant[n]) + CW'(w_pop[n]);
        r_cnt[n]  <= r_cnt[n] + CW'(w_push[n]) - CW'(w_pop[n]);
        if (w_push[n]) r_wptr[n] <= ptr_inc(r_wptr[n]);
        if (w_pop[n])  r_rptr[n] <= ptr_inc(r_rptr[n]);
      end
    end
  end

  // Storage needs no reset: the counts gate everything read out of it.
  always_ff @(posedge clk) begin
    for (int n = 0; n < 2; n++) begin
      if (w_push[n]) r_mem[n][r_wptr[n]] <= {bus.fu_ovf, bus.fu_y};
    end
  end
endmodule
